// File: rtl/game_end_of_game_timer_if.sv
// game_end_of_game_timer_if: start/result handshake and score bus between the master FSM and the end-of-game timer
interface game_end_of_game_timer_if #(parameter int SCORE_DIGITS = 2);
  logic end_of_game_timer_start;
  logic game_won;
  logic score_clear;
  logic end_of_game_timer_running;
  logic result_won;
  logic blink;
  logic [4*SCORE_DIGITS-1:0] wins_bcd;
  logic [4*SCORE_DIGITS-1:0] losses_bcd;
  modport master (
    output end_of_game_timer_start, game_won, score_clear,
    input end_of_game_timer_running, result_won, blink, wins_bcd, losses_bcd
  );
  modport slave (
    input end_of_game_timer_start, game_won, score_clear,
    output end_of_game_timer_running, result_won, blink, wins_bcd, losses_bcd
  );
endinterface

// File: rtl/game_end_of_game_timer.sv
// game_end_of_game_timer: fixed-length end-of-game display period with banner blink and saturating BCD scores
module game_end_of_game_timer #(
  parameter int PRESCALE = 2500000,
  parameter int DURATION_TICKS = 20,
  parameter int BLINK_TICKS = 2,
  parameter int SCORE_DIGITS = 2
) (
  input logic clk,
  input logic reset,
  game_end_of_game_timer_if.slave bus
);
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int RW = $clog2(DURATION_TICKS + 1) > 0 ? $clog2(DURATION_TICKS + 1) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  logic running_q, result_won_q, blink_q;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] rem;
  logic [BW-1:0] bcnt;
  logic [SW-1:0] wins, losses;
  logic accept, tick, last, bwrap;
  // a carry out of the top digit means every digit was 9, so the counter holds
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++)
      if (c) begin
        if (v[4*i+:4] == 4'd9) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = v[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return c ? v : r;
  endfunction
  assign accept = bus.end_of_game_timer_start && !running_q;
  assign tick = running_q && pcnt == PW'(PRESCALE - 1);
  assign last = rem == RW'(1);
  assign bwrap = bcnt == BW'(BLINK_TICKS - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      running_q <= 1'b0;
      result_won_q <= 1'b0;
      blink_q <= 1'b0;
      pcnt <= '0;
      rem <= '0;
      bcnt <= '0;
      wins <= '0;
      losses <= '0;
    end else begin
      if (accept) begin
        running_q <= 1'b1;
        result_won_q <= bus.game_won;
        blink_q <= 1'b1;
        pcnt <= '0;
        rem <= RW'(DURATION_TICKS);
        bcnt <= '0;
      end else if (running_q) begin
        pcnt <= tick ? '0 : pcnt + PW'(1);
        if (tick) begin
          running_q <= !last;
          rem <= rem - RW'(1);
          bcnt <= (last || bwrap) ? '0 : bcnt + BW'(1);
          blink_q <= last ? 1'b0 : (bwrap ? !blink_q : blink_q);
        end
      end
      wins <= bus.score_clear ? '0 : (accept && bus.game_won ? bcd_inc(wins) : wins);
      losses <= bus.score_clear ? '0 : (accept && !bus.game_won ? bcd_inc(losses) : losses);
    end
  assign bus.end_of_game_timer_running = running_q | bus.end_of_game_timer_start;
  assign bus.result_won = result_won_q;
  assign bus.blink = blink_q;
  assign bus.wins_bcd = wins;
  assign bus.losses_bcd = losses;
endmodule

// File: tb/tb_game_end_of_game_timer.sv
// tb_game_end_of_game_timer: directed checks of run length, blink, scores, clear and reset
module tb_game_end_of_game_timer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  game_end_of_game_timer_if #(.SCORE_DIGITS(2)) bus ();
  game_end_of_game_timer_if #(.SCORE_DIGITS(2)) bus1 ();
  game_end_of_game_timer #(.PRESCALE(4), .DURATION_TICKS(3), .BLINK_TICKS(1), .SCORE_DIGITS(2))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));
  game_end_of_game_timer #(.PRESCALE(1), .DURATION_TICKS(3), .BLINK_TICKS(1), .SCORE_DIGITS(2))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic idle_all(input string tag);
    chk({tag, " running"}, {7'd0, bus.end_of_game_timer_running}, 8'h00);
    chk({tag, " result_won"}, {7'd0, bus.result_won}, 8'h00);
    chk({tag, " blink"}, {7'd0, bus.blink}, 8'h00);
    chk({tag, " wins"}, bus.wins_bcd, 8'h00);
    chk({tag, " losses"}, bus.losses_bcd, 8'h00);
  endtask
  task automatic play(input logic won, input logic clr);
    bus.end_of_game_timer_start = 1'b1;
    bus.game_won = won;
    bus.score_clear = clr;
    cyc(1);
    bus.end_of_game_timer_start = 1'b0;
    bus.game_won = 1'b0;
    bus.score_clear = 1'b0;
  endtask
  initial begin
    bus.end_of_game_timer_start = 1'b0;
    bus.game_won = 1'b0;
    bus.score_clear = 1'b0;
    bus1.end_of_game_timer_start = 1'b0;
    bus1.game_won = 1'b0;
    bus1.score_clear = 1'b0;
    @(negedge clk);
    cyc(3);
    idle_all("reset");
    reset = 1'b1;
    cyc(10);
    idle_all("idle");
    // win run with an ignored retrigger mid-run
    bus.end_of_game_timer_start = 1'b1;
    bus.game_won = 1'b1;
    #1 chk("comb running", {7'd0, bus.end_of_game_timer_running}, 8'h01);
    cyc(1);
    bus.end_of_game_timer_start = 1'b0;
    bus.game_won = 1'b0;
    chk("win wins", bus.wins_bcd, 8'h01);
    chk("win losses", bus.losses_bcd, 8'h00);
    chk("win result", {7'd0, bus.result_won}, 8'h01);
    for (int k = 1; k <= 13; k++) begin
      chk($sformatf("run%0d running", k), {7'd0, bus.end_of_game_timer_running}, (k <= 12) ? 8'h01 : 8'h00);
      chk($sformatf("run%0d blink", k), {7'd0, bus.blink}, (k <= 4 || (k >= 9 && k <= 12)) ? 8'h01 : 8'h00);
      bus.end_of_game_timer_start = (k == 4);
      bus.game_won = (k == 4);
      cyc(1);
    end
    chk("retrigger wins", bus.wins_bcd, 8'h01);
    chk("retrigger result", {7'd0, bus.result_won}, 8'h01);
    // loss counter carry and saturation
    for (int n = 1; n <= 100; n++) begin
      play(1'b0, 1'b0);
      if (n == 9) chk("loss 9", bus.losses_bcd, 8'h09);
      if (n == 10) chk("loss 10", bus.losses_bcd, 8'h10);
      if (n == 99) chk("loss 99", bus.losses_bcd, 8'h99);
      if (n == 100) chk("loss sat", bus.losses_bcd, 8'h99);
      cyc(12);
    end
    chk("loss result", {7'd0, bus.result_won}, 8'h00);
    chk("loss wins", bus.wins_bcd, 8'h01);
    chk("loss idle", {7'd0, bus.end_of_game_timer_running}, 8'h00);
    // clear beats same-cycle increment but the run still starts
    play(1'b1, 1'b1);
    chk("clr wins", bus.wins_bcd, 8'h00);
    chk("clr losses", bus.losses_bcd, 8'h00);
    chk("clr result", {7'd0, bus.result_won}, 8'h01);
    cyc(11);
    chk("clr run 12", {7'd0, bus.end_of_game_timer_running}, 8'h01);
    cyc(1);
    chk("clr run 13", {7'd0, bus.end_of_game_timer_running}, 8'h00);
    // reset mid-run
    play(1'b1, 1'b0);
    cyc(5);
    chk("pre-rst running", {7'd0, bus.end_of_game_timer_running}, 8'h01);
    chk("pre-rst wins", bus.wins_bcd, 8'h01);
    reset = 1'b0;
    cyc(1);
    idle_all("midrst");
    reset = 1'b1;
    play(1'b0, 1'b0);
    chk("post-rst losses", bus.losses_bcd, 8'h01);
    cyc(11);
    chk("post-rst run 12", {7'd0, bus.end_of_game_timer_running}, 8'h01);
    cyc(1);
    chk("post-rst run 13", {7'd0, bus.end_of_game_timer_running}, 8'h00);
    // one-cycle prescaler
    bus1.end_of_game_timer_start = 1'b1;
    bus1.game_won = 1'b1;
    cyc(1);
    bus1.end_of_game_timer_start = 1'b0;
    bus1.game_won = 1'b0;
    chk("p1 wins", bus1.wins_bcd, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("p1 run%0d", k), {7'd0, bus1.end_of_game_timer_running}, (k <= 3) ? 8'h01 : 8'h00);
      chk($sformatf("p1 blink%0d", k), {7'd0, bus1.blink}, (k == 1 || k == 3) ? 8'h01 : 8'h00);
      cyc(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
